// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the writeback stage and its scoreboard.
//   REG_AW       - register address width (16 architectural registers)
//   DW           - default datapath width
//   hold_state_t - occupancy of the one-entry load hold buffer
package core_pkg;

  localparam int REG_AW = 4;
  localparam int DW     = 32;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write tracker for the issue stage.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   set_en, set_wc   - an instruction writing register set_wc was issued
//   clr_en, clr_wc   - a register bank write to clr_wc is in flight this cycle
//   busy             - bit i set while register i has a write pending
//   sb_err           - sticky flag: issue to a register that was already busy
// When a set and a clear hit the same register on the same edge, the set wins.
module wb_scoreboard
  import core_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_wc,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_wc,
  output logic [NREG-1:0]   busy,
  output logic              sb_err
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] conflict;
  logic            sb_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;

      assign set_hit = set_en && (set_wc == REG_AW'(gi));
      assign clr_hit = clr_en && (clr_wc == REG_AW'(gi));

      // Set has priority so a re-issue on the clearing edge stays pending.
      assign busy_next[gi] = set_hit ? 1'b1 :
                             clr_hit ? 1'b0 : busy_reg[gi];

      // A bit being cleared on this edge is treated as free, so re-issuing
      // into it is legal and not an error.
      assign conflict[gi] = set_hit && busy_reg[gi] && !clr_hit;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg   <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      busy_reg   <= busy_next;
      sb_err_reg <= sb_err_reg | (|conflict);
    end
  end

  assign busy   = busy_reg;
  assign sb_err = sb_err_reg;

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Merges ALU and load results onto the
// single write port of the register bank and tracks pending writes.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_wc/alu_data - ALU result handshake and payload
//   mem_valid/mem_ready/mem_wc/mem_data - load result handshake and payload
//   iss_valid, iss_wc                 - issue of a register-writing instruction
//   busy, sb_err                      - scoreboard state for the issue stage
//   WC, WPC, W_RB                     - register bank write address/data/strobe
//   byp_valid, byp_wc, byp_data       - forwarding copy of the bank write
// Configuration macro: WB_BYPASS_EN. When defined, byp_* mirror W_RB/WC/WPC;
// otherwise they are tied to zero.
module writeback_stage
  import core_pkg::*;
#(
  parameter int NREG = 16,
  parameter int DW   = core_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_wc,
  input  logic [DW-1:0]     alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_wc,
  input  logic [DW-1:0]     mem_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_wc,
  output logic [NREG-1:0]   busy,
  output logic              sb_err,
  output logic [REG_AW-1:0] WC,
  output logic [DW-1:0]     WPC,
  output logic              W_RB,
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_wc,
  output logic [DW-1:0]     byp_data
);

  hold_state_t       hold_state_reg, hold_state_next;
  logic [REG_AW-1:0] hold_wc_reg, hold_wc_next;
  logic [DW-1:0]     hold_data_reg, hold_data_next;

  logic              sel_valid;
  logic [REG_AW-1:0] sel_wc;
  logic [DW-1:0]     sel_data;

  logic              w_rb_reg;
  logic [REG_AW-1:0] wc_reg;
  logic [DW-1:0]     wpc_reg;

  // Both sources are accepted only while the hold buffer is empty; the
  // buffer absorbs the load that loses arbitration against the ALU.
  assign alu_ready = (hold_state_reg == HOLD_EMPTY);
  assign mem_ready = (hold_state_reg == HOLD_EMPTY);

  always_comb begin
    hold_state_next = hold_state_reg;
    hold_wc_next    = hold_wc_reg;
    hold_data_next  = hold_data_reg;
    sel_valid       = 1'b0;
    sel_wc          = hold_wc_reg;
    sel_data        = hold_data_reg;

    if (hold_state_reg == HOLD_FULL) begin
      // Drain the buffered load; no source is accepted this cycle.
      sel_valid       = 1'b1;
      hold_state_next = HOLD_EMPTY;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel_wc    = alu_wc;
      sel_data  = alu_data;
      if (mem_valid) begin
        hold_wc_next    = mem_wc;
        hold_data_next  = mem_data;
        hold_state_next = HOLD_FULL;
      end
    end else if (mem_valid) begin
      sel_valid = 1'b1;
      sel_wc    = mem_wc;
      sel_data  = mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_state_reg <= HOLD_EMPTY;
      hold_wc_reg    <= '0;
      hold_data_reg  <= '0;
      w_rb_reg       <= 1'b0;
      wc_reg         <= '0;
      wpc_reg        <= '0;
    end else begin
      hold_state_reg <= hold_state_next;
      hold_wc_reg    <= hold_wc_next;
      hold_data_reg  <= hold_data_next;
      w_rb_reg       <= sel_valid;
      // Address/data keep their last values while idle.
      if (sel_valid) begin
        wc_reg  <= sel_wc;
        wpc_reg <= sel_data;
      end
    end
  end

  assign W_RB = w_rb_reg;
  assign WC   = wc_reg;
  assign WPC  = wpc_reg;

  // The clear port sees the registered write, so a bit drops on the edge
  // that ends the W_RB cycle.
  wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (iss_valid),
    .set_wc (iss_wc),
    .clr_en (w_rb_reg),
    .clr_wc (wc_reg),
    .busy   (busy),
    .sb_err (sb_err)
  );

`ifdef WB_BYPASS_EN
  assign byp_valid = w_rb_reg;
  assign byp_wc    = wc_reg;
  assign byp_data  = wpc_reg;
`else
  assign byp_valid = 1'b0;
  assign byp_wc    = '0;
  assign byp_data  = '0;
`endif

endmodule
